unpack_pkt_arbiter: RTL and testbench

//  Packet-granular round-robin arbiter that shares one 32b->7b data_unpack instance between NUM_CH sources.

---
 rtl/unpack_arb_pkg.sv | 18 +
 rtl/unpack_rr_pick.sv | 32 +++
 rtl/unpack_pkt_arbiter.sv | 157 +++++++++++++++
 tb/tb_unpack_pkt_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unpack_arb_pkg.sv
// Shared types and defaults for the packet-granular unpacker arbiter.
package unpack_arb_pkg;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        LOCKED = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_MAX_WORDS = 64;

    // Width of a channel index; never narrower than one bit.
    function automatic int unsigned chan_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/unpack_rr_pick.sv
// Combinational round-robin picker: first request at or after last_grant+1, modulo NUM_CH.
module unpack_rr_pick
    import unpack_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH = 4,
    localparam int unsigned CW     = chan_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CW-1:0]     last_grant,
    output logic [NUM_CH-1:0] gnt_onehot,
    output logic [CW-1:0]     gnt_idx,
    output logic              any
);

    logic [CW-1:0] idx;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = '0;
        for (int unsigned k = 1; k <= NUM_CH; k++) begin
            idx = CW'((32'(last_grant) + k) % NUM_CH);
            if (!any && req[idx]) begin
                any             = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/unpack_pkt_arbiter.sv
// Packet-granular round-robin arbiter feeding one data_unpack instance from NUM_CH sources.
module unpack_pkt_arbiter
    import unpack_arb_pkg::*;
#(
    parameter  int unsigned NUM_CH    = 4,
    parameter  int unsigned DATA_W    = DEF_DATA_W,
    parameter  int unsigned MAX_WORDS = DEF_MAX_WORDS,
    localparam int unsigned CW        = chan_w(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        s_valid,
    output logic [NUM_CH-1:0]        s_ready,
    input  logic [NUM_CH*DATA_W-1:0] s_data,
    input  logic [NUM_CH-1:0]        s_sop,
    input  logic [NUM_CH-1:0]        s_eop,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_sop,
    output logic                     m_eop,
    output logic [CW-1:0]            m_chan,
    output logic                     err
);

    localparam int unsigned      CNT_W    = $clog2(MAX_WORDS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WORDS - 1);

    arb_state_t        state;
    logic [CW-1:0]     grant, last_grant, pick_idx, sel_ch;
    logic [NUM_CH-1:0] req, pick_onehot;
    logic              pick_any;
    logic [CNT_W-1:0]  word_cnt;
    logic              load_en, accept, fwd, trunc, out_sop, out_eop, at_max;
    logic              sel_valid, sel_sop, sel_eop;
    logic [DATA_W-1:0] sel_data;

    assign req     = s_valid & s_sop;
    assign load_en = !m_valid || m_ready;
    assign sel_ch  = (state == ARB) ? pick_idx : grant;
    assign at_max  = (word_cnt == LAST_CNT);

    unpack_rr_pick #(.NUM_CH(NUM_CH)) u_pick (
        .req        (req),
        .last_grant (last_grant),
        .gnt_onehot (pick_onehot),
        .gnt_idx    (pick_idx),
        .any        (pick_any)
    );

    always_comb begin
        sel_valid = 1'b0;
        sel_sop   = 1'b0;
        sel_eop   = 1'b0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (sel_ch == CW'(i)) begin
                sel_valid = s_valid[i];
                sel_sop   = s_sop[i];
                sel_eop   = s_eop[i];
                sel_data  = s_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        s_ready = '0;
        accept  = 1'b0;
        fwd     = 1'b0;
        trunc   = 1'b0;
        out_sop = 1'b0;
        out_eop = 1'b0;
        // Non-granted channels presenting a non-sop word are orphans: accept and drop.
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (s_valid[i] && !s_sop[i] && (state == ARB || grant != CW'(i)))
                s_ready[i] = 1'b1;
        end
        case (state)
            ARB: begin
                accept  = pick_any && load_en;
                fwd     = accept;
                out_sop = 1'b1;
                out_eop = sel_eop;
                s_ready = s_ready | (pick_onehot & {NUM_CH{load_en}});
            end
            LOCKED: begin
                s_ready[grant] = load_en;
                accept  = sel_valid && load_en;
                fwd     = accept;
                out_eop = sel_eop || sel_sop || at_max;
                trunc   = accept && (sel_sop || (at_max && !sel_eop));
            end
            DRAIN: begin
                s_ready[grant] = 1'b1;
                accept         = sel_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ARB;
            grant      <= '0;
            last_grant <= CW'(NUM_CH - 1);
            word_cnt   <= '0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_sop      <= 1'b0;
            m_eop      <= 1'b0;
            m_chan     <= '0;
            err        <= 1'b0;
        end else begin
            err <= trunc;
            if (load_en) begin
                m_valid <= fwd;
                if (fwd) begin
                    m_data <= sel_data;
                    m_sop  <= out_sop;
                    m_eop  <= out_eop;
                    m_chan <= sel_ch;
                end
            end
            // Mid-packet sop outranks the length limit, which outranks a normal eop.
            case (state)
                ARB: if (accept) begin
                    if (sel_eop) begin
                        last_grant <= pick_idx;
                    end else begin
                        grant    <= pick_idx;
                        word_cnt <= CNT_W'(1);
                        state    <= LOCKED;
                    end
                end
                LOCKED: if (accept) begin
                    if (sel_sop) begin
                        last_grant <= grant;
                        state      <= ARB;
                    end else if (at_max && !sel_eop) begin
                        state <= DRAIN;
                    end else if (sel_eop) begin
                        last_grant <= grant;
                        state      <= ARB;
                    end else begin
                        word_cnt <= word_cnt + 1'b1;
                    end
                end
                DRAIN: if (accept && sel_eop) begin
                    last_grant <= grant;
                    state      <= ARB;
                end
                default: state <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_unpack_pkt_arbiter.sv
// Self-checking bench: packet-level round-robin scoreboard for unpack_pkt_arbiter.
module tb_unpack_pkt_arbiter;

    localparam int NCH  = 4;
    localparam int DW   = 32;
    localparam int MAXW = 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
    } word_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic          sop;
        logic          eop;
        logic [1:0]    chan;
    } out_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    s_valid, s_ready, s_sop, s_eop;
    logic [NCH*DW-1:0] s_data;
    logic              m_valid, m_ready, m_sop, m_eop, err;
    logic [DW-1:0]     m_data;
    logic [1:0]        m_chan;

    always #5 clk = ~clk;

    unpack_pkt_arbiter #(.NUM_CH(NCH), .DATA_W(DW), .MAX_WORDS(MAXW)) dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_sop   (s_sop),
        .s_eop   (s_eop),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_sop   (m_sop),
        .m_eop   (m_eop),
        .m_chan  (m_chan),
        .err     (err)
    );

    word_t src_q[NCH][$];
    word_t mdl_q[NCH][$];
    out_t  exp_q[$];
    int    checks = 0, fails = 0;
    int    cyc = 0, ph_step = 0, ph_err = 0, exp_err = 0;
    int    first_v = -1, last_v = -1, nvalid = 0;
    int    sop_acc[NCH];
    int    ready_mode = 0;
    int    lastg = NCH - 1;
    logic  prev_stall = 1'b0;
    out_t  prev_out;

    task automatic push_word(input int ch, input logic [DW-1:0] d, input logic sop,
                             input logic eop, input bit to_model);
        word_t w;
        w = '{data: d, sop: sop, eop: eop};
        src_q[ch].push_back(w);
        if (to_model) mdl_q[ch].push_back(w);
    endtask

    task automatic add_packet(input int ch, input int len, input int orph);
        for (int o = 0; o < orph; o++) push_word(ch, $urandom, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < len; k++) push_word(ch, $urandom, k == 0, k == len - 1, 1'b1);
    endtask

    function automatic bit model_busy();
        for (int c = 0; c < NCH; c++) if (mdl_q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit src_busy();
        for (int c = 0; c < NCH; c++) if (src_q[c].size() != 0) return 1'b1;
        return 1'b0;
    endfunction

    // Whole packets in round-robin order; words past MAXW-1 are cut and the last kept one ends it.
    task automatic model_build();
        int    c, k;
        word_t w;
        while (model_busy()) begin
            c = -1;
            for (int j = 1; j <= NCH; j++)
                if (c < 0 && mdl_q[(lastg + j) % NCH].size() != 0) c = (lastg + j) % NCH;
            k = 0;
            do begin
                w = mdl_q[c].pop_front();
                if (k < MAXW) begin
                    exp_q.push_back('{data: w.data, sop: (k == 0), eop: (w.eop || k == MAXW - 1),
                                      chan: 2'(c)});
                    if (k == MAXW - 1 && !w.eop) exp_err++;
                end
                k++;
            end while (!w.eop && mdl_q[c].size() != 0);
            lastg = c;
        end
    endtask

    task automatic step();
        out_t  obs;
        word_t h;
        @(negedge clk);
        for (int ch = 0; ch < NCH; ch++) begin
            if (src_q[ch].size() != 0) begin
                h = src_q[ch][0];
                s_valid[ch] = 1'b1;
                s_sop[ch]   = h.sop;
                s_eop[ch]   = h.eop;
                s_data[ch*DW +: DW] = h.data;
            end else begin
                s_valid[ch] = 1'b0;
                s_sop[ch]   = 1'b0;
                s_eop[ch]   = 1'b0;
                s_data[ch*DW +: DW] = '0;
            end
        end
        case (ready_mode)
            1:       m_ready = ($urandom_range(0, 99) < 65);
            2:       m_ready = !(ph_step >= 3 && ph_step <= 5);
            default: m_ready = 1'b1;
        endcase
        #1;
        obs = '{data: m_data, sop: m_sop, eop: m_eop, chan: m_chan};
        if (prev_stall) begin
            checks++;
            assert (m_valid === 1'b1 && obs === prev_out) else begin
                fails++;
                $error("FAIL hold_stable: got v=%b %h, expected v=1 %h", m_valid, obs, prev_out);
            end
        end
        if (ready_mode == 2 && m_valid && !m_ready) begin
            checks++;
            assert (s_ready[0] === 1'b0) else begin
                fails++;
                $error("FAIL stall_ready: got s_ready[0]=%b, expected 0", s_ready[0]);
            end
        end
        if (err === 1'b1) ph_err++;
        if (m_valid === 1'b1) begin
            if (first_v < 0) first_v = cyc;
            last_v = cyc;
            nvalid++;
        end
        if (m_valid === 1'b1 && m_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                fails++;
                $error("FAIL extra_word: got data=%h chan=%0d, expected no word", m_data, m_chan);
            end
            if (exp_q.size() != 0) begin
                checks++;
                assert (obs === exp_q[0]) else begin
                    fails++;
                    $error("FAIL out_word: got data=%h sop=%b eop=%b chan=%0d, expected data=%h sop=%b eop=%b chan=%0d",
                           obs.data, obs.sop, obs.eop, obs.chan,
                           exp_q[0].data, exp_q[0].sop, exp_q[0].eop, exp_q[0].chan);
                end
                void'(exp_q.pop_front());
            end
        end
        prev_stall = m_valid && !m_ready;
        prev_out   = obs;
        for (int ch = 0; ch < NCH; ch++) begin
            if (s_valid[ch] && s_ready[ch] === 1'b1) begin
                if (s_sop[ch]) sop_acc[ch] = cyc;
                void'(src_q[ch].pop_front());
            end
        end
        cyc++;
        ph_step++;
    endtask

    task automatic phase_begin();
        ph_step = 0; ph_err = 0; exp_err = 0;
        first_v = -1; last_v = -1; nvalid = 0;
    endtask

    task automatic run_phase(input int max_cycles, input string tag);
        while ((exp_q.size() != 0 || src_busy()) && ph_step < max_cycles) step();
        repeat (3) step();
        checks++;
        assert (exp_q.size() == 0 && !src_busy()) else begin
            fails++;
            $error("FAIL %s_drain: got %0d words still expected, expected 0", tag, exp_q.size());
        end
        checks++;
        assert (ph_err == exp_err) else begin
            fails++;
            $error("FAIL %s_err: got %0d err pulses, expected %0d", tag, ph_err, exp_err);
        end
    endtask

    initial begin
        rst = 1'b1; s_valid = '0; s_sop = '0; s_eop = '0; s_data = '0; m_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        assert ({m_valid, m_sop, m_eop, err} === 4'b0 && m_data === '0 && m_chan === 2'd0) else begin
            fails++;
            $error("FAIL reset_out: got v=%b sop=%b eop=%b err=%b data=%h chan=%0d, expected all 0",
                   m_valid, m_sop, m_eop, err, m_data, m_chan);
        end
        checks++;
        assert (s_ready === '0) else begin
            fails++;
            $error("FAIL reset_ready: got %b, expected 0000", s_ready);
        end
        rst = 1'b0;

        // ch0 and ch2 contend from reset: ch0, ch2, ch0, ch2 with no idle cycles
        phase_begin();
        add_packet(0, 2, 0); add_packet(2, 2, 0); add_packet(0, 2, 0); add_packet(2, 2, 0);
        model_build();
        ready_mode = 0;
        run_phase(200, "rr");
        checks++;
        assert (nvalid == 8 && last_v - first_v + 1 == 8) else begin
            fails++;
            $error("FAIL rr_gap: got %0d valid over span %0d, expected 8 over 8", nvalid, last_v - first_v + 1);
        end

        // single 3-word packet on ch1, one cycle of latency
        phase_begin();
        add_packet(1, 3, 0);
        model_build();
        run_phase(100, "basic");
        checks++;
        assert (first_v == sop_acc[1] + 1 && nvalid == 3 && last_v == first_v + 2) else begin
            fails++;
            $error("FAIL basic_latency: got first=%0d last=%0d n=%0d, expected first=%0d last=%0d n=3",
                   first_v, last_v, nvalid, sop_acc[1] + 1, sop_acc[1] + 3);
        end

        // orphan word ahead of a packet on ch3
        phase_begin();
        push_word(3, 32'hA5, 1'b0, 1'b0, 1'b0);
        push_word(3, 32'h11, 1'b1, 1'b0, 1'b1);
        push_word(3, 32'h22, 1'b0, 1'b1, 1'b1);
        model_build();
        run_phase(100, "orphan");

        // 6-word packet against a 4-word limit
        phase_begin();
        add_packet(0, 6, 0);
        model_build();
        run_phase(100, "maxlen");
        checks++;
        assert (nvalid == 4) else begin
            fails++;
            $error("FAIL maxlen_count: got %0d words out, expected 4", nvalid);
        end

        // back-pressure window mid-packet
        phase_begin();
        add_packet(0, 4, 0);
        model_build();
        ready_mode = 2;
        run_phase(100, "stall");
        ready_mode = 0;

        // mid-packet sop on ch2 while ch1 waits with its own sop
        phase_begin();
        push_word(2, 32'hC0, 1'b1, 1'b0, 1'b0);
        push_word(2, 32'hC1, 1'b0, 1'b0, 1'b0);
        push_word(2, 32'hC2, 1'b1, 1'b0, 1'b0);
        push_word(2, 32'hC3, 1'b0, 1'b0, 1'b0);
        exp_q.push_back('{data: 32'hC0, sop: 1'b1, eop: 1'b0, chan: 2'd2});
        exp_q.push_back('{data: 32'hC1, sop: 1'b0, eop: 1'b0, chan: 2'd2});
        exp_q.push_back('{data: 32'hC2, sop: 1'b0, eop: 1'b1, chan: 2'd2});
        exp_q.push_back('{data: 32'hB0, sop: 1'b1, eop: 1'b0, chan: 2'd1});
        exp_q.push_back('{data: 32'hB1, sop: 1'b0, eop: 1'b1, chan: 2'd1});
        exp_err = 1;
        while (src_q[2].size() > 3 && ph_step < 20) step();
        push_word(1, 32'hB0, 1'b1, 1'b0, 1'b0);
        push_word(1, 32'hB1, 1'b0, 1'b1, 1'b0);
        run_phase(100, "midsop");
        lastg = 1;

        // random packets, lengths and orphans under random back-pressure
        ready_mode = 1;
        for (int it = 0; it < 5; it++) begin
            phase_begin();
            for (int ch = 0; ch < NCH; ch++) begin
                int np;
                np = $urandom_range(0, 2);
                for (int p = 0; p < np; p++)
                    add_packet(ch, $urandom_range(1, 6), (p == 0) ? 0 : $urandom_range(0, 1));
            end
            if (!model_busy()) add_packet(0, 2, 0);
            model_build();
            run_phase(2000, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
